// File: rtl/ring_heater_lock_ctrl_pkg.sv
// Shared types for the ring heater lock controller: FSM state encoding and counter widths.
// The DITHER_P/DITHER_M states and the dither phase type exist only with TRACK_DITHER_EN.
package ring_lock_pkg;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        MEASURE,
        EVAL,
        APPLY,
        SETTLE_L,
        MEAS_L,
        LOCK_CHK
`ifdef TRACK_DITHER_EN
        ,
        DITHER_P,
        DITHER_M
`endif
    } state_e;

`ifdef TRACK_DITHER_EN
    typedef enum logic [1:0] {
        PH_C,
        PH_P,
        PH_M
    } phase_e;
`endif

endpackage

// File: rtl/ring_heater_lock_ctrl_if.sv
// Control/receiver/heater signal bundle between the lock controller and its environment.
interface ring_heater_lock_ctrl_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic                 rx_valid;
    logic                 rx_bit;
    logic [BIT_WIDTH-1:0] heater_code;
    logic                 heater_pdm;
    logic                 locked;
    logic                 busy;
    logic                 lock_fail;

    modport master (
        output start, abort, rx_valid, rx_bit,
        input  heater_code, heater_pdm, locked, busy, lock_fail
    );

    modport slave (
        input  start, abort, rx_valid, rx_bit,
        output heater_code, heater_pdm, locked, busy, lock_fail
    );
endinterface

// File: rtl/ring_heater_lock_ctrl_heater_pdm_gen.sv
// First-order pulse-density modulator: the accumulator carry is the registered heater drive,
// so duty = code / 2^BIT_WIDTH and code 0 never drives high.
module heater_pdm_gen #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] code,
    output logic                 pdm
);
    logic [BIT_WIDTH-1:0] acc_q, acc_d;
    logic                 pdm_q, pdm_d;

    always_comb begin
        {pdm_d, acc_d} = {1'b0, acc_q} + {1'b0, code};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm = pdm_q;
endmodule

// File: rtl/ring_heater_lock_ctrl.sv
// Thermal lock controller: sweeps heater codes, scores each by receiver ones per window,
// applies the best and monitors lock. Define TRACK_DITHER_EN for +1/-1 dither tracking while locked.
module ring_heater_lock_ctrl
    import ring_lock_pkg::*;
#(
    parameter int BIT_WIDTH     = 8,
    parameter int WINDOW        = 64,
    parameter int SETTLE_CYCLES = 1000,
    parameter int LOCK_MIN      = 56
) (
    input logic                   clk,
    input logic                   rst_n,
    ring_heater_lock_ctrl_if.slave bus
);
    localparam int WIN_W = cnt_w(WINDOW);
    localparam int ST_W  = cnt_w(SETTLE_CYCLES);

    localparam logic [WIN_W-1:0]     WINDOW_C    = WIN_W'(WINDOW);
    localparam logic [WIN_W-1:0]     LOCK_MIN_C  = WIN_W'(LOCK_MIN);
    localparam logic [ST_W-1:0]      SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_WIDTH-1:0] CODE_MAX    = {BIT_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] code_q, code_d;
    logic [BIT_WIDTH-1:0] best_code_q, best_code_d;
    logic [WIN_W-1:0]     best_cnt_q, best_cnt_d;
    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]     ones_cnt_q, ones_cnt_d;
    logic [ST_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic                 lock_fail_q, lock_fail_d;
    logic [WIN_W-1:0]     win_inc, ones_inc;
    logic                 locked;

`ifdef TRACK_DITHER_EN
    phase_e               phase_q, phase_d;
    logic [BIT_WIDTH-1:0] center_q, center_d;
    logic [WIN_W-1:0]     center_cnt_q, center_cnt_d;
    logic [WIN_W-1:0]     plus_cnt_q, plus_cnt_d;
    logic [BIT_WIDTH-1:0] tgt_code;

    function automatic logic [BIT_WIDTH-1:0] sat_inc(input logic [BIT_WIDTH-1:0] c);
        return (c == CODE_MAX) ? c : c + BIT_WIDTH'(1);
    endfunction

    function automatic logic [BIT_WIDTH-1:0] sat_dec(input logic [BIT_WIDTH-1:0] c);
        return (c == '0) ? c : c - BIT_WIDTH'(1);
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        best_code_d  = best_code_q;
        best_cnt_d   = best_cnt_q;
        win_cnt_d    = win_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        settle_cnt_d = settle_cnt_q;
        lock_fail_d  = lock_fail_q;
        win_inc      = win_cnt_q + WIN_W'(1);
        ones_inc     = ones_cnt_q + WIN_W'(bus.rx_bit);
`ifdef TRACK_DITHER_EN
        phase_d      = phase_q;
        center_d     = center_q;
        center_cnt_d = center_cnt_q;
        plus_cnt_d   = plus_cnt_q;
        tgt_code     = code_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    code_d      = '0;
                    best_code_d = '0;
                    best_cnt_d  = '0;
                    lock_fail_d = 1'b0;
                    state_d     = SETTLE;
                end
            end
            SETTLE, SETTLE_L: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                    win_cnt_d    = '0;
                    ones_cnt_d   = '0;
                    state_d      = (state_q == SETTLE) ? MEASURE : MEAS_L;
                end else begin
                    settle_cnt_d = settle_cnt_q + ST_W'(1);
                end
            end
            MEASURE, MEAS_L: begin
                if (bus.rx_valid) begin
                    win_cnt_d  = win_inc;
                    ones_cnt_d = ones_inc;
                    if (win_inc == WINDOW_C) begin
                        if (state_q == MEASURE) begin
                            state_d = EVAL;
                        end else begin
`ifdef TRACK_DITHER_EN
                            case (phase_q)
                                PH_P:    state_d = DITHER_P;
                                PH_M:    state_d = DITHER_M;
                                default: state_d = LOCK_CHK;
                            endcase
`else
                            state_d = LOCK_CHK;
`endif
                        end
                    end
                end
            end
            EVAL: begin
                // Strict compare keeps the lowest code on ties.
                if (ones_cnt_q > best_cnt_q) begin
                    best_cnt_d  = ones_cnt_q;
                    best_code_d = code_q;
                end
                if (code_q == CODE_MAX) begin
                    state_d = APPLY;
                end else begin
                    code_d  = code_q + BIT_WIDTH'(1);
                    state_d = SETTLE;
                end
            end
            APPLY: begin
                if (best_cnt_q >= LOCK_MIN_C) begin
                    code_d  = best_code_q;
                    state_d = SETTLE_L;
`ifdef TRACK_DITHER_EN
                    center_d = best_code_q;
                    phase_d  = PH_C;
`endif
                end else begin
                    lock_fail_d = 1'b1;
                    code_d      = '0;
                    state_d     = IDLE;
                end
            end
            LOCK_CHK: begin
                if (ones_cnt_q < LOCK_MIN_C) begin
                    code_d      = '0;
                    best_code_d = '0;
                    best_cnt_d  = '0;
                    state_d     = SETTLE;
                end else begin
                    win_cnt_d  = '0;
                    ones_cnt_d = '0;
`ifdef TRACK_DITHER_EN
                    center_cnt_d = ones_cnt_q;
                    phase_d      = PH_P;
                    tgt_code     = sat_inc(center_q);
                    code_d       = tgt_code;
                    state_d      = (tgt_code != code_q) ? SETTLE_L : MEAS_L;
`else
                    state_d = MEAS_L;
`endif
                end
            end
`ifdef TRACK_DITHER_EN
            DITHER_P: begin
                plus_cnt_d = ones_cnt_q;
                phase_d    = PH_M;
                tgt_code   = sat_dec(center_q);
                code_d     = tgt_code;
                win_cnt_d  = '0;
                ones_cnt_d = '0;
                state_d    = (tgt_code != code_q) ? SETTLE_L : MEAS_L;
            end
            DITHER_M: begin
                // ones_cnt_q holds the c-1 window; c+1 wins when both neighbours beat the center.
                if (plus_cnt_q > center_cnt_q) begin
                    tgt_code = sat_inc(center_q);
                end else if (ones_cnt_q > center_cnt_q) begin
                    tgt_code = sat_dec(center_q);
                end else begin
                    tgt_code = center_q;
                end
                center_d   = tgt_code;
                phase_d    = PH_C;
                code_d     = tgt_code;
                win_cnt_d  = '0;
                ones_cnt_d = '0;
                state_d    = (tgt_code != code_q) ? SETTLE_L : MEAS_L;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (bus.abort) begin
            state_d      = IDLE;
            code_d       = '0;
            win_cnt_d    = '0;
            ones_cnt_d   = '0;
            settle_cnt_d = '0;
`ifdef TRACK_DITHER_EN
            phase_d      = PH_C;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            code_q       <= '0;
            best_code_q  <= '0;
            best_cnt_q   <= '0;
            win_cnt_q    <= '0;
            ones_cnt_q   <= '0;
            settle_cnt_q <= '0;
            lock_fail_q  <= 1'b0;
`ifdef TRACK_DITHER_EN
            phase_q      <= PH_C;
            center_q     <= '0;
            center_cnt_q <= '0;
            plus_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            best_code_q  <= best_code_d;
            best_cnt_q   <= best_cnt_d;
            win_cnt_q    <= win_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            lock_fail_q  <= lock_fail_d;
`ifdef TRACK_DITHER_EN
            phase_q      <= phase_d;
            center_q     <= center_d;
            center_cnt_q <= center_cnt_d;
            plus_cnt_q   <= plus_cnt_d;
`endif
        end
    end

    always_comb begin
        locked = (state_q == SETTLE_L) || (state_q == MEAS_L) || (state_q == LOCK_CHK);
`ifdef TRACK_DITHER_EN
        locked = locked || (state_q == DITHER_P) || (state_q == DITHER_M);
`endif
    end

    heater_pdm_gen #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_pdm (
        .clk  (clk),
        .rst_n(rst_n),
        .code (code_q),
        .pdm  (bus.heater_pdm)
    );

    assign bus.heater_code = code_q;
    assign bus.locked      = locked;
    assign bus.busy        = (state_q != IDLE);
    assign bus.lock_fail   = lock_fail_q;
endmodule

// File: doc/ring_heater_lock_ctrl.md
Name: ring_heater_lock_ctrl

Overview:
Closed-loop thermal lock controller for one electro-optic cell's resonant rings. It sweeps the thermal tuner's heater code and scores each code by counting ones on the current-integrating receiver output over a fixed training window. It then applies the best-scoring code and monitors lock, restarting the sweep on loss of lock. It drives the heater directly through an internal pulse-density modulator (PDM).

Parameters:
BIT_WIDTH, 8, heater code width; PDM duty cycle = code / 2^BIT_WIDTH
WINDOW, 64, number of rx_valid strobes per measurement window
SETTLE_CYCLES, 1000, clocks to wait after any heater code change before measuring (thermal settling)
LOCK_MIN, 56, minimum ones per window for the cell to count as locked

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a sweep from IDLE
abort  in  1  level; forces IDLE and heater off
rx_valid  in  1  receiver bit strobe, one clk wide
rx_bit  in  1  sampled receiver output; training pattern is all-ones
heater_code  out  BIT_WIDTH  current heater code
heater_pdm  out  1  registered PDM heater drive
locked  out  1  high while in LOCKED
busy  out  1  high in any state other than IDLE
lock_fail  out  1  sticky; set when a sweep finds no code at or above LOCK_MIN; cleared by the next start

Behaviour:
- Reset (asynchronous, any state): state=IDLE; heater_code=0; PDM accumulator=0; heater_pdm=0; all counters=0; best_code=0; best_cnt=0; locked=0; lock_fail=0.
- PDM: each clk, {carry, acc} = acc + heater_code, and heater_pdm <= carry. Code 0 never drives high. Code 2^BW-1 drives high on (2^BW-1) of every 2^BW clocks.
- Counters: ones_cnt and win_cnt are $clog2(WINDOW+1) bits wide. settle_cnt is $clog2(SETTLE_CYCLES+1) bits wide.
- IDLE:
  - start=1 and abort=0 -> heater_code=0, best_code=0, best_cnt=0, lock_fail=0 -> SETTLE.
  - start is ignored in every other state.
- SETTLE: settle_cnt counts clocks. After SETTLE_CYCLES clocks, clear win_cnt and ones_cnt -> MEASURE. rx_valid is ignored while settling.
- MEASURE: on each rx_valid, win_cnt+=1 and ones_cnt+=rx_bit. The strobe that makes win_cnt==WINDOW moves to EVAL on the next clk. ones_cnt includes that final strobe's rx_bit.
- EVAL (one clk):
  - If ones_cnt > best_cnt (strict, so the lowest code wins ties), update best_cnt and best_code.
  - If heater_code == 2^BW-1 -> APPLY; else heater_code+=1 -> SETTLE.
  - heater_code never wraps.
- APPLY (one clk):
  - best_cnt >= LOCK_MIN -> heater_code=best_code -> SETTLE_L.
  - Otherwise lock_fail=1, heater_code=0 -> IDLE.
- SETTLE_L / MEAS_L: same as SETTLE / MEASURE, at the locked code. locked=1 from the first cycle of SETTLE_L.
- LOCK_CHK (one clk, the end of each MEAS_L window):
  - ones_cnt < LOCK_MIN -> locked=0, heater_code=0, best cleared -> SETTLE (full re-sweep; lock_fail unchanged).
  - Otherwise -> MEAS_L (no settle between monitor windows).
- abort=1 in any state -> IDLE next clk with heater_code=0 and locked=0. abort takes priority over all other transitions, including start in the same cycle.
- rx_valid together with a state exit in the same clk: the strobe is counted only if the state is MEASURE or MEAS_L.

Optional Feature:
TRACK_DITHER_EN.
- Defined: in locked operation, windows rotate center c -> c+1 -> c-1, with each neighbour code saturating at 0 and 2^BW-1.
  - Each code change inserts SETTLE_CYCLES.
  - After the c-1 window, c moves to whichever neighbour strictly exceeds the center count. If both exceed it, c+1 is chosen; if neither, c is kept.
  - The loss-of-lock check uses the center window only.
- Undefined: plain monitoring as described above; heater_code is constant while locked.

Decomposition:
- Package ring_lock_pkg:
  - state enum: IDLE, SETTLE, MEASURE, EVAL, APPLY, SETTLE_L, MEAS_L, LOCK_CHK, plus DITHER_P and DITHER_M under the macro;
  - counter-width localparam functions.
- Sub-module heater_pdm_gen (accumulator plus carry register, parameterised by BIT_WIDTH) is instantiated once. The remaining FSM and counters stay in the top level.

Test Plan:
All scenarios use BIT_WIDTH=4, WINDOW=8, SETTLE_CYCLES=4, LOCK_MIN=6, rx_valid every 2 clks.
1. Bench ring model gives 8 ones at code 9, 4 at codes 8 and 10, and 0 elsewhere; pulse start -> 16 sweep steps, then heater_code=9, locked=1, lock_fail=0.
2. Model gives 5 ones at every code -> after the sweep lock_fail=1, heater_code=0, busy=0; a new start clears lock_fail.
3. Model gives 8 ones at both codes 3 and 12 -> locks at 3 (tie goes to the lowest code).
4. While locked at 9, the model resonance shifts to code 11 -> after the next window locked=0 and a re-sweep runs, ending locked with heater_code=11.
5. heater_code=5 is held for 32 clks -> heater_pdm high exactly 10 clks; code 0 -> 0 clks high; code 15 -> 30 clks high.
6. abort asserted mid-MEASURE, and separately rst_n deasserted asynchronously mid-SETTLE -> IDLE, heater_code=0, heater_pdm=0 (on reset, immediately without a clock edge); start pulsed in the same cycle as abort is ignored.
